// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: MDU sequencer states and the
// forward-select codes that the datapath operand muxes decode.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // The M stage holds the younger result, so it wins over W.
    function automatic logic [1:0] fwd_sel(input logic m_hit, input logic w_hit);
        if (m_hit) begin
            return FWD_M;
        end
        if (w_hit) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_md_seq_fsm.sv
// Multi-cycle multiply/divide sequencer: holds the pipe for MD_LATENCY cycles
// per op, then pulses done for the cycle the op leaves the execute stage.
module md_seq_fsm
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_WIDTH  = $clog2(MD_LATENCY)
) (
    input  logic i_CLK,
    input  logic i_RST,
    input  logic i_MdStartE,
    output logic busy,
    output logic done,
    output logic stall
);

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(MD_LATENCY - 2);

    md_state_t            state_reg;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic                 busy_reg;
    logic                 done_reg;

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_reg <= MD_IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                MD_IDLE: begin
                    if (i_MdStartE) begin
                        state_reg <= MD_BUSY;
                        cnt_reg   <= CNT_LOAD;
                        busy_reg  <= 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (cnt_reg == '0) begin
                        state_reg <= MD_DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_WIDTH'(1);
                    end
                end
                // Start is ignored here: the op that just finished is still in E.
                MD_DONE: begin
                    state_reg <= MD_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= MD_IDLE;
                    cnt_reg   <= '0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;

    // The IDLE term stalls the very first cycle the op sits in E. Gating with
    // reset keeps the pipe free while the controller is held in reset.
    assign stall = i_RST &&
                   (((state_reg == MD_IDLE) && i_MdStartE) || (state_reg == MD_BUSY));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: forwarding
// selects, stall/flush of the pipeline registers, and the MDU sequencer.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MD_LATENCY     = 32,
    parameter int CNT_WIDTH      = $clog2(MD_LATENCY)
) (
    input  logic                      i_CLK,
    input  logic                      i_RST,
    input  logic [REG_ADDR_WIDTH-1:0] i_RsD,
    input  logic [REG_ADDR_WIDTH-1:0] i_RtD,
    input  logic [REG_ADDR_WIDTH-1:0] i_RsE,
    input  logic [REG_ADDR_WIDTH-1:0] i_RtE,
    input  logic [REG_ADDR_WIDTH-1:0] i_WriteRegE,
    input  logic [REG_ADDR_WIDTH-1:0] i_WriteRegM,
    input  logic [REG_ADDR_WIDTH-1:0] i_WriteRegW,
    input  logic                      i_RegWriteE,
    input  logic                      i_RegWriteM,
    input  logic                      i_RegWriteW,
    input  logic                      i_MemtoRegE,
    input  logic                      i_MemtoRegM,
    input  logic                      i_BranchD,
    input  logic                      i_PCSrcD,
    input  logic                      i_MdStartE,
    output logic                      o_StallF,
    output logic                      o_StallD,
    output logic                      o_FlushD,
    output logic                      o_StallE,
    output logic                      o_FlushE,
    output logic                      o_FlushM,
    output logic                      o_ForwardAD,
    output logic                      o_ForwardBD,
    output logic [1:0]                o_ForwardAE,
    output logic [1:0]                o_ForwardBE,
    output logic                      o_MdBusy,
    output logic                      o_MdDone
);

    // Index 0 is the Rs operand, index 1 the Rt operand.
    logic [REG_ADDR_WIDTH-1:0] src_d [2];
    logic [REG_ADDR_WIDTH-1:0] src_e [2];
    logic [1:0]                fwd_e [2];
    logic                      fwd_d [2];
    logic                      lw_hit [2];
    logic                      br_hit [2];

    logic lwstall;
    logic branchstall;
    logic mdstall;
    logic stall_fd;

    assign src_d[0] = i_RsD;
    assign src_d[1] = i_RtD;
    assign src_e[0] = i_RsE;
    assign src_e[1] = i_RtE;

    // $0 is hardwired to zero, so a match on it never creates a hazard.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            logic d_nz;
            logic e_nz;

            assign d_nz = (src_d[gi] != '0);
            assign e_nz = (src_e[gi] != '0);

            assign fwd_e[gi] = fwd_sel(e_nz && (src_e[gi] == i_WriteRegM) && i_RegWriteM,
                                       e_nz && (src_e[gi] == i_WriteRegW) && i_RegWriteW);

            assign fwd_d[gi] = d_nz && (src_d[gi] == i_WriteRegM) && i_RegWriteM;

            assign lw_hit[gi] = d_nz && (i_RtE == src_d[gi]);

            // The branch comparator needs its operands in D, so an ALU result
            // still in E or a load still in M forces a wait.
            assign br_hit[gi] = d_nz &&
                                ((i_RegWriteE && (i_WriteRegE == src_d[gi])) ||
                                 (i_MemtoRegM && (i_WriteRegM == src_d[gi])));
        end
    endgenerate

    md_seq_fsm #(
        .MD_LATENCY (MD_LATENCY),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_md_seq (
        .i_CLK      (i_CLK),
        .i_RST      (i_RST),
        .i_MdStartE (i_MdStartE),
        .busy       (o_MdBusy),
        .done       (o_MdDone),
        .stall      (mdstall)
    );

    assign lwstall     = i_MemtoRegE && (lw_hit[0] || lw_hit[1]);
    assign branchstall = i_BranchD && (br_hit[0] || br_hit[1]);
    assign stall_fd    = lwstall || branchstall || mdstall;

    assign o_StallF = stall_fd;
    assign o_StallD = stall_fd;
    assign o_StallE = mdstall;

    // A held E stage must keep its MDU op, so the bubble waits until the MDU frees it.
    assign o_FlushE = (lwstall || branchstall) && !mdstall;
    assign o_FlushM = mdstall;
    assign o_FlushD = i_PCSrcD && !stall_fd;

    assign o_ForwardAE = fwd_e[0];
    assign o_ForwardBE = fwd_e[1];
    assign o_ForwardAD = fwd_d[0];
    assign o_ForwardBD = fwd_d[1];

endmodule
